// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the RV32M/RV64M multiply/divide unit.
//   func3_e : M-extension funct3 encodings
//   state_e : sequencer states of muldiv_unit
//   is_signed_a / is_signed_b : operand signedness for a given funct3
// ---------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } func3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    // rs1 is treated as signed for everything except the fully unsigned ops
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    // rs2 is additionally unsigned for MULHSU
    function automatic logic is_signed_b(input logic [2:0] f3);
        return is_signed_a(f3) && (f3 != F3_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One iteration of restoring division on unsigned magnitudes.
//   rem_in       : current partial remainder (always < divisor)
//   dividend_bit : next dividend bit shifted in, MSB first
//   divisor      : divisor magnitude
//   rem_out      : partial remainder for the next iteration
//   q_bit        : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Because rem_in < divisor, the shifted value is below 2*divisor, so the
    // trial difference is non-negative exactly when its top bit is clear.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[XLEN];
        rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle M-extension execute unit (MUL/MULH/MULHSU/MULHU and
// DIV/DIVU/REM/REMU) with a start/done handshake and a kill abort.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request, sampled only while busy is low
//   kill       : abort any in-flight operation (outranks start)
//   func3      : M-extension funct3, captured with start
//   a, b       : rs1/rs2 operands, captured with start
//   busy       : operation in flight, new starts are dropped
//   done       : one-cycle pulse, result valid
//   result     : last completed result, held until the next completion
// Latency: multiply 2, divide by zero / signed overflow 1, divide XLEN+2.
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state;
    func3_e          op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] rem;
    logic            neg_q;
    logic            neg_r;
    logic [CW-1:0]   cnt;

    logic            div_signed;
    logic            b_zero;
    logic            overflow;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;

    // Decode of the incoming request: magnitudes for the divider and the
    // results of the cases that complete without iterating.
    always_comb begin
        div_signed  = func3[2] & ~func3[0];
        b_zero      = (b == '0);
        overflow    = div_signed && (a == MIN_NEG) && (b == '1);
        a_mag       = (div_signed && a[XLEN-1]) ? -a : a;
        b_mag       = (div_signed && b[XLEN-1]) ? -b : b;
        if (b_zero)
            special_res = func3[1] ? a : '1;
        else
            special_res = func3[1] ? '0 : a;
    end

    logic signed [XLEN:0]     mul_a;
    logic signed [XLEN:0]     mul_b;
    logic signed [2*XLEN+1:0] prod;
    logic [1:0]               unused_prod_top;
    logic [XLEN-1:0]          mul_res;

    // Each operand is widened by one bit (sign or zero) so a single signed
    // multiplier covers all three signedness combinations.
    always_comb begin
        mul_a   = {is_signed_a(op) & opa[XLEN-1], opa};
        mul_b   = {is_signed_b(op) & opb[XLEN-1], opb};
        prod    = (2*XLEN+2)'(mul_a) * (2*XLEN+2)'(mul_b);
        mul_res = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign unused_prod_top = prod[2*XLEN+1:2*XLEN];

    logic [XLEN-1:0] rem_next;
    logic            q_bit;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (rem),
        .dividend_bit (opa[XLEN-1]),
        .divisor      (opb),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    logic [XLEN-1:0] quot_signed;
    logic [XLEN-1:0] rem_signed;
    logic [XLEN-1:0] fix_res;

    // Sign restoration once the magnitudes are divided; funct3 bit 1
    // distinguishes the remainder ops from the quotient ops.
    always_comb begin
        quot_signed = neg_q ? -opa : opa;
        rem_signed  = neg_r ? -rem : rem;
        fix_res     = op[1] ? rem_signed : quot_signed;
    end

    assign busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);

    // Sequencer. During DIV the dividend register shifts left and collects
    // quotient bits at the bottom, so after XLEN steps opa holds the quotient
    // and rem holds the remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op     <= F3_MUL;
            opa    <= '0;
            opb    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (kill) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (start) begin
                        op <= func3_e'(func3);
                        if (!func3[2]) begin
                            state <= ST_MUL;
                            opa   <= a;
                            opb   <= b;
                        end else if (b_zero || overflow) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            result <= special_res;
                        end else begin
                            state <= ST_DIV;
                            opa   <= a_mag;
                            opb   <= b_mag;
                            rem   <= '0;
                            cnt   <= CW'(XLEN);
                            neg_q <= div_signed & (a[XLEN-1] ^ b[XLEN-1]);
                            neg_r <= div_signed & a[XLEN-1];
                        end
                    end
                end
                ST_MUL: begin
                    result <= mul_res;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DIV: begin
                    rem <= rem_next;
                    opa <= {opa[XLEN-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M/RV64M execute unit for multiply and divide, the next generation of our ALU path. Replaces the single "mul" ALU control code with full M-extension coverage. Covers all eight funct3 operations, with a start/done handshake and a kill input. Sits beside the ALU in the execute stage; the controller stalls the pipeline while `busy` is high.

## Interface
- `XLEN`, 32, operand/result width; must be even and ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `kill`  in  1  synchronous abort of an in-flight operation.
- `func3`  in  3  M-extension funct3, captured with `start`.
- `a`, `b`  in  XLEN  rs1/rs2 operands, captured with `start`.
- `busy`  out  1  operation in flight; new `start` ignored.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  XLEN  last completed result. Held until the next completion.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. `busy` = state ∈ {MUL, DIV, FIX}.
- Accepted start (IDLE or DONE):
  - mul group (func3[2]=0) → MUL.
  - div group with b=0 or signed overflow → DONE directly.
  - other div ops → DIV.
- MUL: form the 2·XLEN product of a and b.
  - Extension per func3: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; all others return the high XLEN bits. → DONE.
- DIV: restoring division on magnitudes.
  - Operands are made absolute for signed DIV/REM at capture.
  - One quotient bit per cycle, XLEN cycles, using down-counter `cnt` of width $clog2(XLEN)+1. Load XLEN; leave when `cnt` reaches 1 → FIX.
- FIX: apply signs.
  - Quotient negated iff sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - DIV/DIVU select the quotient; REM/REMU select the remainder. → DONE.
- Special cases, resolved without iterating:
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a=−2^(XLEN−1), b=−1, DIV/REM): DIV → a; REM → 0.
- DONE: `done`=1 for exactly one cycle, `result` registered. → IDLE, unless a start is accepted the same cycle.
- `kill` (any state) → IDLE next edge. No `done`; `result` unchanged. `kill` outranks `start` in the same cycle.
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, `cnt`=0.

## Timing
- Cycle 0 is the edge sampling `start`.
- MUL: `done` in cycle 2 (latency 2).
- Special-case div: `done` in cycle 1.
- Normal div: XLEN cycles in DIV, 1 in FIX, `done` in cycle XLEN+2. For XLEN=32, latency is 34.
- Back-to-back: a start in a DONE cycle is accepted. Throughput is one op per latency.
- `a`, `b`, `func3` are don't-care after the start cycle.
- `start` while `busy`=1 is dropped with no queuing. The controller must hold the request until accepted.
- Reset mid-operation behaves identically to `kill`, and additionally clears `result`.

## Structure
- Package `muldiv_pkg`:
  - funct3 enum: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - state enum.
  - Helper predicates `is_signed_a(func3)` and `is_signed_b(func3)`.
- Sub-module `div_step`:
  - Combinational, parametrised on XLEN.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once and reused each DIV cycle.
- Multiplier inferred as one (XLEN+1)×(XLEN+1) signed product in the MUL state.

## Test plan
- MULH a=0x80000000, b=0x80000000 → `done` at cycle 2, result=0x40000000. MUL with the same operands → 0x00000000.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → result=0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- DIV a=−7 (0xFFFFFFF9), b=2 → result 0xFFFFFFFD at cycle 34. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF at cycle 1. REM a=5, b=0 → 5. DIV 0x80000000/−1 → 0x80000000. REM 0x80000000/−1 → 0.
- Start DIV; assert `kill` at cycle 10 → `busy` low at cycle 11, no `done`, `result` retains the prior value. Repeat with `reset` in place of `kill` → `result`=0.
- Start pulse while `busy` → ignored. Start in the DONE cycle → new op accepted and completes at the expected latency.
